lifelike_grid: RTL and testbench

- Parametrised successor to the fixed 16x16 toroidal Life array.
- Computes Life-like cellular automata (B/S rule set by parameter) on a ROWS x COLS grid.
- Supports toroidal or dead-boundary edges.
- Adds a control FSM (load / single-step / free-run / auto-halt), a generation counter and extinct/stable detection.
- Sits between the pattern loader and the display/scan-out logic.

---
 rtl/lifelike_grid.sv | 156 +++++++++++++++
 tb/tb_lifelike_grid.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lifelike_grid.sv
// lifelike_grid: parametrised Life-like cellular automaton on a ROWS x COLS grid.
// Every cell's next state is computed in parallel, one generation per clock.
// A small control FSM (IDLE / RUN / HALT) sequences loading, single-stepping
// and free-running. It halts automatically when the grid is extinct or stable.
// Optional feature macro: LIFELIKE_PERIOD2_DETECT_EN adds period-2 oscillation
// detection through a prev-generation register. When the macro is undefined,
// osc2 is tied low.
module lifelike_grid #(
  parameter int          ROWS    = 16,
  parameter int          COLS    = 16,
  parameter bit          WRAP    = 1'b1,
  parameter logic [8:0]  BIRTH   = 9'b000001000,
  parameter logic [8:0]  SURVIVE = 9'b000001100,
  parameter int          GEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] pattern,
  input  logic                 run,
  input  logic                 step,
  output logic [ROWS*COLS-1:0] cells,
  output logic [GEN_W-1:0]     gen_count,
  output logic [1:0]           state,
  output logic                 extinct,
  output logic                 stable,
  output logic                 osc2
);

  localparam int N = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t           state_q;
  logic [N-1:0]     cells_q;
  logic [N-1:0]     next_cells_d;
  logic [GEN_W-1:0] gen_q;
  logic             stable_q;
  logic             adv_d;
  logic             same_d;

  // Per-cell neighbour count and rule lookup, all cells in parallel
  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    localparam int R = gi / COLS;
    localparam int C = gi % COLS;
    logic [3:0] cnt_d;

    // Sum the eight neighbours; off-grid ones wrap or count as dead
    always_comb begin
      int rr;
      int cc;
      cnt_d = 4'd0;
      rr = 0;
      cc = 0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          if (!(dr == 0 && dc == 0)) begin
            rr = R + dr;
            cc = C + dc;
            if (WRAP) begin
              rr = (rr + ROWS) % ROWS;
              cc = (cc + COLS) % COLS;
              cnt_d = cnt_d + {3'd0, cells_q[rr*COLS+cc]};
            end else if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
              cnt_d = cnt_d + {3'd0, cells_q[rr*COLS+cc]};
            end
          end
        end
      end
    end

    assign next_cells_d[gi] = cells_q[gi] ? SURVIVE[cnt_d] : BIRTH[cnt_d];
  end

  assign extinct = ~|cells_q;
  assign same_d  = (next_cells_d == cells_q);

  // An advance happens on a step pulse from IDLE (run low), or on every live RUN cycle
  assign adv_d = ((state_q == IDLE) && !run && step) ||
                 ((state_q == RUN) && run && !extinct);

`ifdef LIFELIKE_PERIOD2_DETECT_EN
  logic [N-1:0] prev_q;
  logic         prev_valid_q;
  logic         osc2_q;
`endif

  // Control FSM plus grid, counter and flag registers; reset > load > FSM action
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cells_q  <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
`ifdef LIFELIKE_PERIOD2_DETECT_EN
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      osc2_q       <= 1'b0;
`endif
    end else if (load) begin
      state_q  <= IDLE;
      cells_q  <= pattern;
      gen_q    <= '0;
      stable_q <= 1'b0;
`ifdef LIFELIKE_PERIOD2_DETECT_EN
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      osc2_q       <= 1'b0;
`endif
    end else if (adv_d) begin
      if (same_d) begin
        // Fixed point reached: freeze everything and halt
        stable_q <= 1'b1;
        state_q  <= HALT;
      end else begin
        cells_q  <= next_cells_d;
        stable_q <= 1'b0;
        if (gen_q != {GEN_W{1'b1}}) begin
          gen_q <= gen_q + 1'b1;
        end
`ifdef LIFELIKE_PERIOD2_DETECT_EN
        prev_q       <= cells_q;
        prev_valid_q <= 1'b1;
        // Returning to the generation before last means a period-2 cycle
        if ((state_q == RUN) && prev_valid_q && (next_cells_d == prev_q)) begin
          osc2_q  <= 1'b1;
          state_q <= HALT;
        end
`endif
      end
    end else begin
      case (state_q)
        IDLE:    if (run) state_q <= RUN;
        RUN:     if (!run) state_q <= IDLE;
                 else if (extinct) state_q <= HALT;
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cells     = cells_q;
  assign gen_count = gen_q;
  assign state     = state_q;
  assign stable    = stable_q;
`ifdef LIFELIKE_PERIOD2_DETECT_EN
  assign osc2 = osc2_q;
`else
  assign osc2 = 1'b0;
`endif

endmodule

// File: tb/tb_lifelike_grid.sv
// Directed testbench for lifelike_grid: three instances
// (5x5 dead-edge, 8x8 torus, 8x8 torus with 3-bit generation counter).
module tb_lifelike_grid;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 5x5, dead boundary
  logic        a_load = 0, a_run = 0, a_step = 0;
  logic [24:0] a_pat = '0, a_cells;
  logic [15:0] a_gen;
  logic [1:0]  a_state;
  logic        a_ext, a_stb, a_osc;

  // Instance B: 8x8 torus
  logic        b_load = 0, b_run = 0, b_step = 0;
  logic [63:0] b_pat = '0, b_cells;
  logic [15:0] b_gen;
  logic [1:0]  b_state;
  logic        b_ext, b_stb, b_osc;

  // Instance C: 8x8 torus, GEN_W=3
  logic        c_load = 0, c_run = 0, c_step = 0;
  logic [63:0] c_pat = '0, c_cells;
  logic [2:0]  c_gen;
  logic [1:0]  c_state;
  logic        c_ext, c_stb, c_osc;

  lifelike_grid #(.ROWS(5), .COLS(5), .WRAP(1'b0)) u_a (
    .clk(clk), .reset(reset), .load(a_load), .pattern(a_pat), .run(a_run), .step(a_step),
    .cells(a_cells), .gen_count(a_gen), .state(a_state), .extinct(a_ext), .stable(a_stb), .osc2(a_osc));

  lifelike_grid #(.ROWS(8), .COLS(8), .WRAP(1'b1)) u_b (
    .clk(clk), .reset(reset), .load(b_load), .pattern(b_pat), .run(b_run), .step(b_step),
    .cells(b_cells), .gen_count(b_gen), .state(b_state), .extinct(b_ext), .stable(b_stb), .osc2(b_osc));

  lifelike_grid #(.ROWS(8), .COLS(8), .WRAP(1'b1), .GEN_W(3)) u_c (
    .clk(clk), .reset(reset), .load(c_load), .pattern(c_pat), .run(c_run), .step(c_step),
    .cells(c_cells), .gen_count(c_gen), .state(c_state), .extinct(c_ext), .stable(c_stb), .osc2(c_osc));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance n clock edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] c5(input int r, input int c);
    logic [63:0] v;
    v = '0;
    v[r*5+c] = 1'b1;
    return v;
  endfunction

  // Glider (.O./..O/OOO) with top-left corner at (r0,c0) on an 8x8 torus
  function automatic logic [63:0] glider8(input int r0, input int c0);
    logic [63:0] v;
    v = '0;
    v[((r0+0)%8)*8 + (c0+1)%8] = 1'b1;
    v[((r0+1)%8)*8 + (c0+2)%8] = 1'b1;
    v[((r0+2)%8)*8 + (c0+0)%8] = 1'b1;
    v[((r0+2)%8)*8 + (c0+1)%8] = 1'b1;
    v[((r0+2)%8)*8 + (c0+2)%8] = 1'b1;
    return v;
  endfunction

  logic [63:0] vert, horiz, blk, single, g0, g12;

  initial begin
    vert   = c5(1,2) | c5(2,2) | c5(3,2);
    horiz  = c5(2,1) | c5(2,2) | c5(2,3);
    blk    = c5(1,1) | c5(1,2) | c5(2,1) | c5(2,2);
    single = c5(2,2);
    g0     = glider8(3, 3);
    g12    = 64'd0;
    g12[6*8+7] = 1'b1; g12[7*8+0] = 1'b1; g12[0*8+6] = 1'b1;
    g12[0*8+7] = 1'b1; g12[0*8+0] = 1'b1;

    // Reset state
    tick(2);
    chk("rst_cells", 64'(a_cells), 64'd0);
    chk("rst_gen",   64'(a_gen), 64'd0);
    chk("rst_state", 64'(a_state), 64'd0);
    chk("rst_flags", {61'd0, a_stb, a_osc, a_ext}, 64'd1);
    chk("rst_b",     b_cells, 64'd0);
    reset = 1'b0;

    // Blinker single-step on 5x5 dead-edge grid
    a_pat = vert[24:0]; a_load = 1; tick(1); a_load = 0;
    chk("load_cells", 64'(a_cells), vert);
    a_step = 1; tick(1); a_step = 0;
    chk("step1_cells", 64'(a_cells), horiz);
    chk("step1_gen",   64'(a_gen), 64'd1);
    chk("step1_state", 64'(a_state), 64'd0);
    a_step = 1; tick(1); a_step = 0;
    chk("step2_cells", 64'(a_cells), vert);
    chk("step2_gen",   64'(a_gen), 64'd2);
    tick(1);
    chk("idle_hold", 64'(a_cells), vert);

    // Still-life block halts on the first RUN cycle
    a_pat = blk[24:0]; a_load = 1; tick(1); a_load = 0;
    a_run = 1; tick(1);
    chk("blk_enter", 64'(a_state), 64'd1);
    tick(1);
    chk("blk_stable", 64'(a_stb), 64'd1);
    chk("blk_state",  64'(a_state), 64'd2);
    chk("blk_gen",    64'(a_gen), 64'd0);
    chk("blk_cells",  64'(a_cells), blk);
    a_run = 0; a_step = 1; tick(1); a_step = 0;
    chk("halt_step", {a_cells, 5'(a_gen), a_state}, {blk[24:0], 5'd0, 2'd2});
    a_run = 1; tick(2);
    chk("halt_run", 64'(a_state), 64'd2);

    // Single cell dies: extinct, then halt (load wins over run still high)
    a_pat = single[24:0]; a_load = 1; tick(1); a_load = 0;
    chk("sgl_load", {a_cells, a_state}, {single[24:0], 2'd0});
    tick(1);
    chk("sgl_run", 64'(a_state), 64'd1);
    tick(1);
    chk("sgl_cells", 64'(a_cells), 64'd0);
    chk("sgl_ext",   64'(a_ext), 64'd1);
    chk("sgl_gen",   64'(a_gen), 64'd1);
    tick(1);
    chk("sgl_halt",  {a_gen, a_state}, {16'd1, 2'd2});
    a_run = 0;

    // Blinker free-run: period-2 detection only with the optional feature
    a_pat = vert[24:0]; a_load = 1; tick(1); a_load = 0;
    a_run = 1; tick(3);
    chk("osc_cells", 64'(a_cells), vert);
    chk("osc_gen",   64'(a_gen), 64'd2);
`ifdef LIFELIKE_PERIOD2_DETECT_EN
    chk("osc_state", {a_state, a_osc}, {2'd2, 1'b1});
    tick(1);
    chk("osc_hold",  {a_cells, a_gen}, {vert[24:0], 16'd2});
`else
    chk("osc_state", {a_state, a_osc}, {2'd1, 1'b0});
    tick(1);
    chk("osc_cont",  {a_cells, a_gen}, {horiz[24:0], 16'd3});
`endif

    // Load mid-run, then reset mid-run
    a_pat = single[24:0]; a_load = 1; tick(1); a_load = 0;
    chk("mid_load", {a_cells, a_gen, a_state}, {single[24:0], 16'd0, 2'd0});
    tick(1);
    chk("mid_run", 64'(a_state), 64'd1);
    reset = 1; tick(1); reset = 0;
    chk("mid_rst", {a_cells, a_gen, a_state}, {25'd0, 16'd0, 2'd0});
    a_run = 0;

    // Glider on 8x8 torus: edge crossing at gen 12, home again at gen 32
    b_pat = g0; b_load = 1; c_pat = g0; c_load = 1; tick(1);
    b_load = 0; c_load = 0;
    b_run = 1; c_run = 1; tick(13);
    chk("gl12_cells", b_cells, g12);
    chk("gl12_gen",   64'(b_gen), 64'd12);
    chk("sat_gen",    64'(c_gen), 64'd7);
    chk("sat_state",  64'(c_state), 64'd1);
    tick(20);
    chk("gl32_gen",   64'(b_gen), 64'd32);
    b_run = 0; c_run = 0; tick(1);
    chk("gl32_cells", b_cells, g0);
    chk("gl32_end",   {b_gen, b_state, b_stb}, {16'd32, 2'd0, 1'b0});
    chk("sat_hold",   64'(c_gen), 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
